// File: rtl/counter_seq_ctrl.sv
// Command-driven interval timer sequencer: prescaled up-count from 0 to a
// programmed limit, one-shot or auto-reload, with START/PAUSE/STOP commands.
module counter_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             reload_q, reload_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             cmd_ready_q, cmd_ready_d;

  logic             cmd_act;
  logic             en;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      presc_q     <= '0;
      limit_q     <= '0;
      reload_q    <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      limit_q     <= limit_d;
      reload_q    <= reload_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Next-state: an accepted command always takes priority over a count step
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    presc_d     = presc_q;
    limit_d     = limit_q;
    reload_d    = reload_q;
    tick_d      = 1'b0;
    cmd_act     = cmd_valid && cmd_ready_q && (cmd_op != OP_NOP);
    en          = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    if (cmd_act) begin
      case (cmd_op)
        OP_START: begin
          limit_d  = cmd_limit;
          reload_d = cmd_reload;
          count_d  = '0;
          presc_d  = '0;
          state_d  = ST_RUN;
        end
        OP_PAUSE: begin
          if (state_q == ST_RUN) begin
            state_d = ST_PAUSED;
          end else if (state_q == ST_PAUSED) begin
            state_d = ST_RUN;
          end
        end
        OP_STOP: begin
          count_d = '0;
          presc_d = '0;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end else if (state_q == ST_RUN) begin
      presc_d = en ? '0 : presc_q + PW'(1);
      if (en) begin
        // Compare before increment so limit = all-ones never wraps
        if (count_q == limit_q) begin
          tick_d = 1'b1;
          if (reload_q) begin
            count_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
    end

    busy_d      = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    done_d      = (state_d == ST_DONE);
    cmd_ready_d = !cmd_act;
  end

  assign count     = count_q;
  assign busy      = busy_q;
  assign tick      = tick_q;
  assign done      = done_q;
  assign cmd_ready = cmd_ready_q;

endmodule
